// File: rtl/output_writer_pkg.sv
// Shared widths, FSM state type and address helper for the output writer.
package output_writer_pkg;

  localparam int SRAM_DATA_WIDTH = 64;
  localparam int ADDR_WIDTH      = 8;
  localparam int DATA_WIDTH      = 8;
  localparam int DATA_LENGTH     = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int COUNT_WIDTH     = ADDR_WIDTH + 3;
  localparam int LANE_WIDTH      = $clog2(DATA_LENGTH);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} writer_state_t;

  // Word address of byte index k: base + k/8, wrapping at the SRAM size.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [ADDR_WIDTH-1:0]  base,
    input logic [COUNT_WIDTH-1:0] byte_idx
  );
    logic [COUNT_WIDTH-1:0] word_idx;
    word_idx = byte_idx >> LANE_WIDTH;
    return base + word_idx[ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/output_writer_if.sv
// Control, result-stream, host-read and status signals of the output writer.
// Handshake: the byte stream has no backpressure; a byte is taken in any cycle
// where i_data_valid is high while packing, and o_read_valid follows i_read_en by one cycle.
interface output_writer_if;
  import output_writer_pkg::*;

  logic                       i_reg_clear;
  logic                       i_start;
  logic [ADDR_WIDTH-1:0]      i_start_addr;
  logic [COUNT_WIDTH-1:0]     i_write_size;
  logic [DATA_WIDTH-1:0]      i_data;
  logic                       i_data_valid;
  logic                       i_read_en;
  logic [ADDR_WIDTH-1:0]      i_read_addr;
  logic [SRAM_DATA_WIDTH-1:0] o_read_data;
  logic                       o_read_valid;
  logic                       o_busy;
  logic                       o_done;
  logic                       o_overflow;

  modport master (
    output i_reg_clear, i_start, i_start_addr, i_write_size, i_data, i_data_valid,
           i_read_en, i_read_addr,
    input  o_read_data, o_read_valid, o_busy, o_done, o_overflow
  );

  modport slave (
    input  i_reg_clear, i_start, i_start_addr, i_write_size, i_data, i_data_valid,
           i_read_en, i_read_addr,
    output o_read_data, o_read_valid, o_busy, o_done, o_overflow
  );

endinterface

// File: rtl/output_writer_byte_packer.sv
// Collects bytes into lanes of one SRAM word; a flush request commits a partial word.
module output_writer_byte_packer
  import output_writer_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic                       i_clear,
  input  logic                       i_valid,
  input  logic                       i_flush,
  input  logic [DATA_WIDTH-1:0]      i_byte,
  output logic [SRAM_DATA_WIDTH-1:0] o_word,
  output logic                       o_word_ready
);

  logic [SRAM_DATA_WIDTH-1:0] lanes_q;
  logic [LANE_WIDTH-1:0]      lane_q;

  // Lanes are zeroed after each commit, so unfilled lanes of a flushed word read as zero.
  always_comb begin
    o_word = lanes_q;
    for (int l = 0; l < DATA_LENGTH; l++) begin
      if (lane_q == LANE_WIDTH'(l)) o_word[l*DATA_WIDTH +: DATA_WIDTH] = i_byte;
    end
    o_word_ready = i_valid && (i_flush || (lane_q == LANE_WIDTH'(DATA_LENGTH - 1)));
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      lanes_q <= '0;
      lane_q  <= '0;
    end else if (i_clear || o_word_ready) begin
      lanes_q <= '0;
      lane_q  <= '0;
    end else if (i_valid) begin
      lanes_q <= o_word;
      lane_q  <= lane_q + LANE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/output_writer_sram.sv
// Single-port-write / single-port-read output SRAM; a same-cycle read sees the old word.
module output_writer_sram
  import output_writer_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic                       i_wr_en,
  input  logic [ADDR_WIDTH-1:0]      i_wr_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] i_wr_data,
  input  logic                       i_rd_en,
  input  logic [ADDR_WIDTH-1:0]      i_rd_addr,
  output logic [SRAM_DATA_WIDTH-1:0] o_rd_data,
  output logic                       o_rd_valid
);

  logic [SRAM_DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) o_rd_data <= mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/output_writer.sv
// Packs a serial result-byte stream into 64-bit words and writes them to the output SRAM.
module output_writer
  import output_writer_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_nrst,
  output_writer_if.slave     bus,
  output writer_state_t      o_state
);

  writer_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]      start_addr_q;
  logic [COUNT_WIDTH-1:0]     size_q;
  logic [COUNT_WIDTH-1:0]     cnt_q;
  logic                       wr_en_q;
  logic [ADDR_WIDTH-1:0]      wr_addr_q;
  logic [SRAM_DATA_WIDTH-1:0] wr_data_q;
  logic                       overflow_q;

  logic                       arm;
  logic                       accept;
  logic                       last_byte;
  logic [SRAM_DATA_WIDTH-1:0] packed_word;
  logic                       word_ready;

  always_comb begin
    arm       = bus.i_start && ((state_q == IDLE) || (state_q == DONE));
    accept    = (state_q == PACK) && bus.i_data_valid && !bus.i_reg_clear;
    last_byte = accept && (cnt_q == size_q - COUNT_WIDTH'(1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (arm) state_d = (bus.i_write_size == '0) ? DONE : PACK;
      PACK:       if (last_byte) state_d = FLUSH;
      FLUSH:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
    if (bus.i_reg_clear) state_d = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= IDLE;
      start_addr_q <= '0;
      size_q       <= '0;
      cnt_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      overflow_q   <= 1'b0;
    end else if (bus.i_reg_clear) begin
      state_q      <= IDLE;
      start_addr_q <= '0;
      size_q       <= '0;
      cnt_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= word_ready;
      // Address uses the index of the byte that completed the word.
      if (word_ready) begin
        wr_addr_q <= word_addr(start_addr_q, cnt_q);
        wr_data_q <= packed_word;
      end
      if (arm) begin
        start_addr_q <= bus.i_start_addr;
        size_q       <= bus.i_write_size;
        cnt_q        <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + COUNT_WIDTH'(1);
      end
      if (bus.i_data_valid && (state_q != PACK)) overflow_q <= 1'b1;
    end
  end

  output_writer_byte_packer u_packer (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_clear      (bus.i_reg_clear),
    .i_valid      (accept),
    .i_flush      (last_byte),
    .i_byte       (bus.i_data),
    .o_word       (packed_word),
    .o_word_ready (word_ready)
  );

  output_writer_sram u_sram (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_wr_en    (wr_en_q),
    .i_wr_addr  (wr_addr_q),
    .i_wr_data  (wr_data_q),
    .i_rd_en    (bus.i_read_en),
    .i_rd_addr  (bus.i_read_addr),
    .o_rd_data  (bus.o_read_data),
    .o_rd_valid (bus.o_read_valid)
  );

  assign bus.o_busy     = (state_q == PACK) || (state_q == FLUSH);
  assign bus.o_done     = (state_q == DONE);
  assign bus.o_overflow = overflow_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_output_writer.sv
// Bench for output_writer: directed vector table, multi-cycle corner sequences and random jobs.
module tb_output_writer;
  import output_writer_pkg::*;

  logic          clk  = 1'b0;
  logic          nrst = 1'b0;
  writer_state_t st;

  output_writer_if bus();

  output_writer dut (
    .i_clk   (clk),
    .i_nrst  (nrst),
    .bus     (bus),
    .o_state (st)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] mdl_mem   [256];
  bit          mdl_known [256];
  logic [7:0]  job_bytes [$];
  logic [63:0] exp_q     [$];
  logic [7:0]  exp_addr_q[$];
  bit          ovf_exp;

  typedef struct {
    logic [7:0]  addr;
    int          size;
    logic [7:0]  first;
    int          gap_mode;
    int          nwords;
    logic [7:0]  a0;
    logic [63:0] w0;
    logic [7:0]  a1;
    logic [63:0] w1;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic host_read(input logic [7:0] a, output logic [63:0] d);
    bus.i_read_en   = 1'b1;
    bus.i_read_addr = a;
    tick();
    bus.i_read_en   = 1'b0;
    check("read_valid", 64'(bus.o_read_valid), 64'd1);
    d = bus.o_read_data;
  endtask

  // Reference: byte i of the job lands in word i/8, lane i%8, at start+i/8 mod 256.
  task automatic model_job(input logic [7:0] addr, input int size);
    int          nw;
    logic [63:0] word;
    logic [7:0]  a;
    nw = (size + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int l = 0; l < 8; l++) begin
        if (w * 8 + l < size) word[l*8 +: 8] = job_bytes[w*8 + l];
      end
      a = 8'(int'(addr) + w);
      mdl_mem[a]   = word;
      mdl_known[a] = 1'b1;
      exp_q.push_back(word);
      exp_addr_q.push_back(a);
    end
  endtask

  task automatic drain_scoreboard();
    logic [63:0] d, e;
    logic [7:0]  a;
    while (exp_q.size() > 0) begin
      a = exp_addr_q.pop_front();
      e = exp_q.pop_front();
      host_read(a, d);
      check("sram_word", d, e);
    end
  endtask

  // gap_mode 0: back-to-back, 1: two idle cycles with an ignored i_start, 2: random gaps
  task automatic run_job(input logic [7:0] addr, input int size, input int gap_mode);
    bus.i_start      = 1'b1;
    bus.i_start_addr = addr;
    bus.i_write_size = 11'(size);
    tick();
    bus.i_start      = 1'b0;
    check("busy_after_start", 64'(bus.o_busy), 64'd1);
    for (int i = 0; i < size; i++) begin
      bus.i_data_valid = 1'b1;
      bus.i_data       = job_bytes[i];
      tick();
      bus.i_data_valid = 1'b0;
      if (i != size - 1) begin
        if (gap_mode == 1) begin
          bus.i_start      = 1'b1;
          bus.i_start_addr = 8'hEE;
          bus.i_write_size = 11'd3;
          tick();
          bus.i_start = 1'b0;
          tick();
        end else if (gap_mode == 2) begin
          repeat ($urandom_range(0, 2)) tick();
        end
      end
    end
    check("flush_state", 64'(st), 64'(FLUSH));
    check("flush_busy", 64'(bus.o_busy), 64'd1);
    tick();
    check("done_after_flush", 64'(bus.o_done), 64'd1);
    model_job(addr, size);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [63:0] d;
    logic [7:0]  a;
    int          sz;

    bus.i_reg_clear  = 1'b0;
    bus.i_start      = 1'b0;
    bus.i_start_addr = '0;
    bus.i_write_size = '0;
    bus.i_data       = '0;
    bus.i_data_valid = 1'b0;
    bus.i_read_en    = 1'b0;
    bus.i_read_addr  = '0;
    ovf_exp          = 1'b0;
    for (int i = 0; i < 256; i++) mdl_known[i] = 1'b0;

    vecs[0] = '{8'h10, 8,  8'h01, 0, 1, 8'h10, 64'h0807060504030201, 8'h00, 64'h0};
    vecs[1] = '{8'h20, 11, 8'hA0, 0, 2, 8'h20, 64'hA7A6A5A4A3A2A1A0, 8'h21, 64'h0000000000AAA9A8};
    vecs[2] = '{8'hFF, 16, 8'h30, 0, 2, 8'hFF, 64'h3736353433323130, 8'h00, 64'h3F3E3D3C3B3A3938};
    vecs[3] = '{8'h40, 8,  8'h01, 1, 1, 8'h40, 64'h0807060504030201, 8'h00, 64'h0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_state",      64'(st),               64'(IDLE));
    check("rst_busy",       64'(bus.o_busy),       64'd0);
    check("rst_done",       64'(bus.o_done),       64'd0);
    check("rst_overflow",   64'(bus.o_overflow),   64'd0);
    check("rst_read_valid", 64'(bus.o_read_valid), 64'd0);
    check("rst_read_data",  bus.o_read_data,       64'd0);
    nrst = 1'b1;
    tick();

    // Directed vector table
    for (int v = 0; v < 4; v++) begin
      job_bytes.delete();
      for (int j = 0; j < vecs[v].size; j++) job_bytes.push_back(8'(int'(vecs[v].first) + j));
      run_job(vecs[v].addr, vecs[v].size, vecs[v].gap_mode);
      host_read(vecs[v].a0, d);
      check("vec_word0", d, vecs[v].w0);
      if (vecs[v].nwords == 2) begin
        host_read(vecs[v].a1, d);
        check("vec_word1", d, vecs[v].w1);
      end
      drain_scoreboard();
    end
    check("no_overflow_yet", 64'(bus.o_overflow), 64'd0);

    // Zero-size job: straight to DONE, nothing written
    bus.i_start      = 1'b1;
    bus.i_start_addr = 8'h10;
    bus.i_write_size = 11'd0;
    tick();
    bus.i_start = 1'b0;
    check("size0_done",  64'(bus.o_done), 64'd1);
    check("size0_state", 64'(st),         64'(DONE));
    tick();
    host_read(8'h10, d);
    check("size0_no_write", d, 64'h0807060504030201);

    // Stray byte in DONE: sticky overflow until clear
    bus.i_data_valid = 1'b1;
    bus.i_data       = 8'h99;
    tick();
    bus.i_data_valid = 1'b0;
    check("overflow_set", 64'(bus.o_overflow), 64'd1);
    job_bytes.delete();
    for (int j = 0; j < 8; j++) job_bytes.push_back(8'(8'h81 + j));
    run_job(8'h50, 8, 0);
    drain_scoreboard();
    check("overflow_sticky_job", 64'(bus.o_overflow), 64'd1);
    bus.i_reg_clear = 1'b1;
    tick();
    bus.i_reg_clear = 1'b0;
    check("overflow_cleared", 64'(bus.o_overflow), 64'd0);
    check("clear_state",      64'(st),             64'(IDLE));

    // Reset mid-PACK: no write issued
    job_bytes.delete();
    for (int j = 0; j < 8; j++) job_bytes.push_back(8'(8'h51 + j));
    run_job(8'h30, 8, 0);
    drain_scoreboard();
    bus.i_start      = 1'b1;
    bus.i_start_addr = 8'h30;
    bus.i_write_size = 11'd8;
    tick();
    bus.i_start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      bus.i_data_valid = 1'b1;
      bus.i_data       = 8'(8'h61 + j);
      tick();
    end
    bus.i_data_valid = 1'b0;
    nrst = 1'b0;
    #1;
    check("mid_rst_state",     64'(st),               64'(IDLE));
    check("mid_rst_done",      64'(bus.o_done),       64'd0);
    check("mid_rst_busy",      64'(bus.o_busy),       64'd0);
    check("mid_rst_rd_valid",  64'(bus.o_read_valid), 64'd0);
    check("mid_rst_rd_data",   bus.o_read_data,       64'd0);
    tick();
    nrst = 1'b1;
    tick();
    host_read(8'h30, d);
    check("mid_rst_no_write", d, mdl_mem[8'h30]);

    // Restart; read in the write cycle sees the old word, the next cycle the new one
    bus.i_start      = 1'b1;
    bus.i_start_addr = 8'h30;
    bus.i_write_size = 11'd8;
    tick();
    bus.i_start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      bus.i_data_valid = 1'b1;
      bus.i_data       = 8'(8'h71 + j);
      tick();
    end
    bus.i_data_valid = 1'b0;
    bus.i_read_en    = 1'b1;
    bus.i_read_addr  = 8'h30;
    tick();
    bus.i_read_en = 1'b0;
    check("same_cycle_old_word", bus.o_read_data, mdl_mem[8'h30]);
    check("restart_done",        64'(bus.o_done), 64'd1);
    mdl_mem[8'h30] = 64'h7877767574737271;
    host_read(8'h30, d);
    check("restart_word", d, 64'h7877767574737271);

    // Clear and start together: clear wins
    bus.i_reg_clear  = 1'b1;
    bus.i_start      = 1'b1;
    bus.i_start_addr = 8'h60;
    bus.i_write_size = 11'd8;
    tick();
    bus.i_reg_clear = 1'b0;
    bus.i_start     = 1'b0;
    check("clear_start_state", 64'(st),         64'(IDLE));
    check("clear_start_busy",  64'(bus.o_busy), 64'd0);
    ovf_exp = 1'b0;

    // Random jobs against the reference model
    for (int r = 0; r < 25; r++) begin
      a  = 8'($urandom_range(0, 255));
      sz = $urandom_range(1, 40);
      job_bytes.delete();
      for (int j = 0; j < sz; j++) job_bytes.push_back(8'($urandom_range(0, 255)));
      run_job(a, sz, ($urandom_range(0, 1) == 1) ? 2 : 0);
      drain_scoreboard();
      if ($urandom_range(0, 3) == 0) begin
        bus.i_data_valid = 1'b1;
        bus.i_data       = 8'($urandom_range(0, 255));
        tick();
        bus.i_data_valid = 1'b0;
        ovf_exp = 1'b1;
      end
      check("rand_overflow", 64'(bus.o_overflow), 64'(ovf_exp));
      a = 8'($urandom_range(0, 255));
      if (mdl_known[a]) begin
        host_read(a, d);
        check("rand_revisit", d, mdl_mem[a]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
